// File: rtl/vga_pkg.sv
// vga_pkg -- shared definitions for the framebuffer scan-out block.
//   Colour constants : BLACK, BLUE, PURPLE, L_BLUE, WHITE (3-bit RGB)
//   Mode encodings   : vga_mode_e (palette, mono, colour bars, black)
//   default_pal()    : reset contents of the colour palette
package vga_pkg;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] BLUE   = 3'b001;
  localparam logic [2:0] PURPLE = 3'b101;
  localparam logic [2:0] L_BLUE = 3'b011;
  localparam logic [2:0] WHITE  = 3'b111;

  typedef enum logic [1:0] {
    MODE_PAL   = 2'b00,
    MODE_MONO  = 2'b01,
    MODE_BARS  = 2'b10,
    MODE_BLACK = 2'b11
  } vga_mode_e;

  // A 1-bit palette is a plain black/white pair; wider palettes start with
  // four useful colours and leave the remaining entries black.
  function automatic logic [2:0] default_pal(input int bpp, input int idx);
    logic [2:0] colour;
    colour = BLACK;
    if (bpp == 1) begin
      colour = (idx == 0) ? BLACK : WHITE;
    end else begin
      case (idx)
        0:       colour = BLUE;
        1:       colour = PURPLE;
        2:       colour = L_BLUE;
        3:       colour = WHITE;
        default: colour = BLACK;
      endcase
    end
    return colour;
  endfunction

endpackage

// File: rtl/vga_palette.sv
// vga_palette -- 2^BPP x 3-bit colour look-up table.
//   clk_25  : pixel clock
//   rst_n   : synchronous active-low reset, loads default_pal() contents
//   pal_we  : write strobe; pal_idx/pal_rgb are written at the clock edge
//   rd_idx  : combinational read index
//   rd_rgb  : colour stored at rd_idx (old value during a same-cycle write)
module vga_palette
  import vga_pkg::*;
#(
  parameter int BPP = 2
) (
  input  logic           clk_25,
  input  logic           rst_n,
  input  logic           pal_we,
  input  logic [BPP-1:0] pal_idx,
  input  logic [2:0]     pal_rgb,
  input  logic [BPP-1:0] rd_idx,
  output logic [2:0]     rd_rgb
);

  localparam int N_ENTRY = 1 << BPP;

  logic [2:0] pal_rd [N_ENTRY];

  generate
    for (genvar gi = 0; gi < N_ENTRY; gi++) begin : g_entry
      logic [2:0] entry_reg;

      always_ff @(posedge clk_25) begin
        if (!rst_n) begin
          entry_reg <= default_pal(BPP, gi);
        end else if (pal_we && (pal_idx == BPP'(gi))) begin
          entry_reg <= pal_rgb;
        end
      end

      assign pal_rd[gi] = entry_reg;
    end
  endgenerate

  assign rd_rgb = pal_rd[rd_idx];

endmodule

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout -- reads a low-resolution framebuffer and scales it up to
// the raster of an external VGA timing generator.
//   clk_25     : pixel clock, all logic on the rising edge
//   rst_n      : synchronous active-low reset
//   h_count    : raw horizontal timing counter (frame start at h=v=0)
//   v_count    : raw vertical timing counter
//   bright     : visible-region qualifier
//   data       : framebuffer read data, RD_LAT cycles after pixel_addr
//   mode       : display mode, latched at frame start
//   pal_we     : palette write strobe
//   pal_idx    : palette write index
//   pal_rgb    : palette write colour
//   pixel_addr : registered framebuffer read address
//   rd_en      : high when pixel_addr is a valid fetch
//   rgb        : registered pixel colour
module vga_fb_scanout
  import vga_pkg::*;
#(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int SCALE  = 4,
  parameter int BPP    = 2,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 15
) (
  input  logic              clk_25,
  input  logic              rst_n,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic              bright,
  input  logic [BPP-1:0]    data,
  input  logic [1:0]        mode,
  input  logic              pal_we,
  input  logic [BPP-1:0]    pal_idx,
  input  logic [2:0]        pal_rgb,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              rd_en,
  output logic [2:0]        rgb
);

  localparam int X_W = $clog2(FB_W);
  localparam int Y_W = $clog2(FB_H + 1);

  // Raster position in framebuffer coordinates
  logic [X_W-1:0]    fb_x_reg;
  logic [1:0]        x_sub_reg;
  logic [Y_W-1:0]    fb_y_reg;
  logic [1:0]        y_sub_reg;
  logic [ADDR_W-1:0] line_base_reg;
  logic              bright_reg;
  vga_mode_e         mode_reg;
  logic              synced_reg;

  // Fetch stage: qualifiers captured alongside pixel_addr
  logic              f_bright_reg;
  logic              f_oor_reg;
  logic [X_W-1:0]    f_x_reg;

  // Delay line that lines the fetch qualifiers up with data
  logic              dly_bright_reg [1:RD_LAT];
  logic              dly_oor_reg    [1:RD_LAT];
  logic [X_W-1:0]    dly_x_reg      [1:RD_LAT];

  logic              frame_start;
  logic              bright_fall;
  logic              out_of_range;
  logic              fetch;
  logic [2:0]        pal_colour;
  logic [2:0]        colour_next;

  assign frame_start  = (h_count == 10'd0) && (v_count == 10'd0);
  assign bright_fall  = bright_reg & ~bright;
  assign out_of_range = (fb_y_reg >= Y_W'(FB_H));
  // Until the first frame start the raster position is meaningless, so no
  // fetches are issued.
  assign fetch        = bright & ~out_of_range & synced_reg;

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      fb_x_reg      <= '0;
      x_sub_reg     <= '0;
      fb_y_reg      <= '0;
      y_sub_reg     <= '0;
      line_base_reg <= '0;
      bright_reg    <= 1'b0;
      mode_reg      <= MODE_PAL;
      synced_reg    <= 1'b0;
      pixel_addr    <= '0;
      rd_en         <= 1'b0;
      f_bright_reg  <= 1'b0;
      f_oor_reg     <= 1'b0;
      f_x_reg       <= '0;
    end else begin
      bright_reg <= bright;
      if (frame_start) begin
        // Frame start wins over everything else. If it lands on a visible
        // pixel that pixel is fetched from address 0 and the horizontal
        // counters step past it, exactly as if counting had begun at 0.
        fb_y_reg      <= '0;
        y_sub_reg     <= '0;
        line_base_reg <= '0;
        mode_reg      <= vga_mode_e'(mode);
        synced_reg    <= 1'b1;
        pixel_addr    <= '0;
        rd_en         <= bright;
        f_bright_reg  <= bright;
        f_oor_reg     <= 1'b0;
        f_x_reg       <= '0;
        if (bright) begin
          x_sub_reg <= 2'((SCALE == 1) ? 0 : 1);
          fb_x_reg  <= X_W'((SCALE == 1) ? 1 : 0);
        end else begin
          x_sub_reg <= '0;
          fb_x_reg  <= '0;
        end
      end else begin
        rd_en        <= fetch;
        f_bright_reg <= bright & synced_reg;
        f_oor_reg    <= out_of_range;
        f_x_reg      <= fb_x_reg;
        if (fetch) begin
          pixel_addr <= line_base_reg + ADDR_W'(fb_x_reg);
        end
        if (bright_fall) begin
          x_sub_reg <= '0;
          fb_x_reg  <= '0;
          if (y_sub_reg == 2'(SCALE - 1)) begin
            y_sub_reg <= '0;
            // Once past the last line the position freezes so neither
            // fb_y nor line_base can run off the end of the buffer.
            if (!out_of_range) begin
              fb_y_reg      <= fb_y_reg + Y_W'(1);
              line_base_reg <= line_base_reg + ADDR_W'(FB_W);
            end
          end else begin
            y_sub_reg <= y_sub_reg + 2'(1);
          end
        end else if (bright) begin
          if (x_sub_reg == 2'(SCALE - 1)) begin
            x_sub_reg <= '0;
            // Saturate so an over-long visible region repeats the last pixel
            if (fb_x_reg != X_W'(FB_W - 1)) begin
              fb_x_reg <= fb_x_reg + X_W'(1);
            end
          end else begin
            x_sub_reg <= x_sub_reg + 2'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      for (int i = 1; i <= RD_LAT; i++) begin
        dly_bright_reg[i] <= 1'b0;
        dly_oor_reg[i]    <= 1'b0;
        dly_x_reg[i]      <= '0;
      end
    end else begin
      dly_bright_reg[1] <= f_bright_reg;
      dly_oor_reg[1]    <= f_oor_reg;
      dly_x_reg[1]      <= f_x_reg;
      for (int i = 2; i <= RD_LAT; i++) begin
        dly_bright_reg[i] <= dly_bright_reg[i-1];
        dly_oor_reg[i]    <= dly_oor_reg[i-1];
        dly_x_reg[i]      <= dly_x_reg[i-1];
      end
    end
  end

  vga_palette #(
    .BPP (BPP)
  ) u_palette (
    .clk_25  (clk_25),
    .rst_n   (rst_n),
    .pal_we  (pal_we),
    .pal_idx (pal_idx),
    .pal_rgb (pal_rgb),
    .rd_idx  (data),
    .rd_rgb  (pal_colour)
  );

  always_comb begin
    colour_next = BLACK;
    if (synced_reg && dly_bright_reg[RD_LAT] && !dly_oor_reg[RD_LAT]) begin
      case (mode_reg)
        MODE_PAL:  colour_next = pal_colour;
        MODE_MONO: colour_next = {3{data[0]}};
        // Eight equal-width vertical bars across the framebuffer width
        MODE_BARS: colour_next = 3'(dly_x_reg[RD_LAT] / X_W'(FB_W / 8));
        default:   colour_next = BLACK;
      endcase
    end
  end

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      rgb <= BLACK;
    end else begin
      rgb <= colour_next;
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout -- directed bench for vga_fb_scanout. Two instances share
// all inputs: u_dut_a uses the defaults (RD_LAT=1), u_dut_b uses RD_LAT=3.
// Stimulus is driven one scan line at a time; one line is printed per line.
module tb_vga_fb_scanout;

  logic        clk_25;
  logic        rst_n;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        bright;
  logic [1:0]  data;
  logic [1:0]  mode;
  logic        pal_we;
  logic [1:0]  pal_idx;
  logic [2:0]  pal_rgb;

  logic [14:0] addr_a, addr_b;
  logic        rd_en_a, rd_en_b;
  logic [2:0]  rgb_a, rgb_b;

  int n_checks = 0;
  int n_errors = 0;
  int exp_addr = 0;

  vga_fb_scanout u_dut_a (
    .clk_25     (clk_25),
    .rst_n      (rst_n),
    .h_count    (h_count),
    .v_count    (v_count),
    .bright     (bright),
    .data       (data),
    .mode       (mode),
    .pal_we     (pal_we),
    .pal_idx    (pal_idx),
    .pal_rgb    (pal_rgb),
    .pixel_addr (addr_a),
    .rd_en      (rd_en_a),
    .rgb        (rgb_a)
  );

  vga_fb_scanout #(
    .RD_LAT (3)
  ) u_dut_b (
    .clk_25     (clk_25),
    .rst_n      (rst_n),
    .h_count    (h_count),
    .v_count    (v_count),
    .bright     (bright),
    .data       (data),
    .mode       (mode),
    .pal_we     (pal_we),
    .pal_idx    (pal_idx),
    .pal_rgb    (pal_rgb),
    .pixel_addr (addr_b),
    .rd_en      (rd_en_b),
    .rgb        (rgb_b)
  );

  initial clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge that consumed the inputs.
  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  // Expected colour of the pixel whose bright cycle was j, seen at tick i.
  function automatic logic [2:0] pix_colour(input int j, input int i, input int blen,
                                            input bit bars, input logic [2:0] col,
                                            input int wr_tick, input logic [2:0] wr_col);
    int fx;
    if (j < 0 || j >= blen) return 3'b000;
    fx = (j / 4 > 159) ? 159 : j / 4;
    if (bars) return 3'(fx / 20);
    if (wr_tick >= 0 && i > wr_tick) return wr_col;
    return col;
  endfunction

  // One scan line: h_count runs 0..htot-1, bright for the first blen cycles.
  // base is the expected line_base; oor marks lines past the framebuffer;
  // dead_in marks a line that starts before the first frame start.
  task automatic run_line(input int v, input int blen, input int htot, input int base,
                          input bit oor, input bit dead_in, input bit bars,
                          input logic [2:0] col, input int wr_tick,
                          input logic [2:0] wr_col, input int rst_tick);
    bit dead;
    bit fetch;
    dead = dead_in;
    for (int i = 0; i < htot; i++) begin
      h_count = 10'(i);
      v_count = 10'(v);
      bright  = (i < blen);
      rst_n   = !(rst_tick >= 0 && i >= rst_tick && i < rst_tick + 3);
      pal_we  = (i == wr_tick);
      pal_idx = 2'd0;
      pal_rgb = wr_col;
      tick();
      if (!rst_n) dead = 1'b1;
      fetch = (i < blen) && !oor && !dead;
      if (fetch) exp_addr = base + ((i / 4 > 159) ? 159 : i / 4);
      check_val("rd_en_a", int'(rd_en_a), int'(fetch));
      check_val("rd_en_b", int'(rd_en_b), int'(fetch));
      if (!dead) begin
        check_val("addr_a", int'(addr_a), exp_addr);
        check_val("addr_b", int'(addr_b), exp_addr);
      end
      if (dead || oor) begin
        check_val("rgb_a", int'(rgb_a), 0);
        check_val("rgb_b", int'(rgb_b), 0);
      end else begin
        check_val("rgb_a", int'(rgb_a), int'(pix_colour(i - 2, i, blen, bars, col, wr_tick, wr_col)));
        check_val("rgb_b", int'(rgb_b), int'(pix_colour(i - 4, i, blen, bars, col, wr_tick, wr_col)));
      end
    end
    rst_n  = 1'b1;
    pal_we = 1'b0;
    bright = 1'b0;
    $display("line v=%0d bright=%0d mode=%0d data=%0d base=%0d oor=%0d dead=%0d errors=%0d",
             v, blen, mode, data, base, oor, dead, n_errors);
  endtask

  initial begin
    rst_n   = 1'b0;
    h_count = 10'd5;
    v_count = 10'd5;
    bright  = 1'b0;
    data    = 2'b11;
    mode    = 2'b00;
    pal_we  = 1'b0;
    pal_idx = 2'd0;
    pal_rgb = 3'b000;

    // Reset state
    for (int i = 0; i < 3; i++) tick();
    check_val("reset_addr_a", int'(addr_a), 0);
    check_val("reset_rd_en_a", int'(rd_en_a), 0);
    check_val("reset_rgb_a", int'(rgb_a), 0);
    check_val("reset_addr_b", int'(addr_b), 0);
    check_val("reset_rd_en_b", int'(rd_en_b), 0);
    check_val("reset_rgb_b", int'(rgb_b), 0);
    rst_n = 1'b1;

    // Reset released mid-frame: nothing shows until the first frame start
    run_line(300, 640, 700, 0, 1'b0, 1'b1, 1'b0, 3'b000, -1, 3'b000, -1);

    // Palette mode, data=3 -> 111; four replayed lines then line base 160;
    // line 5 is over-long and saturates at fb_x=159
    for (int v = 0; v < 5; v++)
      run_line(v, 640, 700, (v / 4) * 160, 1'b0, 1'b0, 1'b0, 3'b111, -1, 3'b000, -1);
    run_line(5, 660, 700, 160, 1'b0, 1'b0, 1'b0, 3'b111, -1, 3'b000, -1);

    // Mode change mid-frame is ignored: still palette, pal[1]=101
    mode = 2'b01;
    data = 2'b01;
    run_line(6, 640, 700, 160, 1'b0, 1'b0, 1'b0, 3'b101, -1, 3'b000, -1);

    // Mono takes effect at the next frame start
    run_line(0, 640, 700, 0, 1'b0, 1'b0, 1'b0, 3'b111, -1, 3'b000, -1);
    data = 2'b10;
    run_line(1, 640, 700, 0, 1'b0, 1'b0, 1'b0, 3'b000, -1, 3'b000, -1);

    // Colour bars, then black mode (fetches continue, colour is 000)
    mode = 2'b10;
    run_line(0, 640, 700, 0, 1'b0, 1'b0, 1'b1, 3'b000, -1, 3'b000, -1);
    mode = 2'b11;
    data = 2'b11;
    run_line(0, 640, 700, 0, 1'b0, 1'b0, 1'b0, 3'b000, -1, 3'b000, -1);

    // Palette write of idx0 = 100 at tick 300 of a data=0 line
    mode = 2'b00;
    data = 2'b00;
    run_line(0, 640, 700, 0, 1'b0, 1'b0, 1'b0, 3'b001, -1, 3'b000, -1);
    run_line(1, 640, 700, 0, 1'b0, 1'b0, 1'b0, 3'b001, 300, 3'b100, -1);

    // Reset held 3 cycles mid-line, dead until next frame start
    data = 2'b11;
    run_line(2, 640, 700, 0, 1'b0, 1'b0, 1'b0, 3'b111, -1, 3'b000, 200);
    run_line(3, 640, 700, 0, 1'b0, 1'b1, 1'b0, 3'b111, -1, 3'b000, -1);
    run_line(0, 640, 700, 0, 1'b0, 1'b0, 1'b0, 3'b111, -1, 3'b000, -1);

    // 500 short bright lines: lines 480 onward are out of range
    for (int v = 0; v < 500; v++)
      run_line(v, 8, 14, (v / 4) * 160, (v >= 480), 1'b0, 1'b0, 3'b111, -1, 3'b000, -1);
    check_val("oor_addr_hold_a", int'(addr_a), 119 * 160 + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
